// File: rtl/branch_predict_judge.sv
// Decode-stage branch resolver with a direct-mapped BHT of 2-bit saturating counters.
// Define PERF_CNT_EN to add the perf_branches / perf_mispred counters. Branch codes: EQ=1 NEQ=2 GEZ=3 GTZ=4 LEZ=5 LTZ=6.
module branch_predict_judge #(
  parameter int         DATA_W    = 32,
  parameter int         BHT_DEPTH = 64,
  parameter logic [1:0] CNT_INIT  = 2'b01
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [31:0]       pcF,
  output logic              pred_takenF,
  input  logic              stallD,
  input  logic              flushD,
  input  logic [DATA_W-1:0] srca2D,
  input  logic [DATA_W-1:0] srcb2D,
  input  logic [2:0]        branchcontrolD,
  input  logic              branchD,
  output logic              pcsrcD,
  output logic              pred_takenD,
  output logic              mispredictD
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       perf_branches,
  output logic [31:0]       perf_mispred
`endif
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] BRANCH_EQ  = 3'b001;
  localparam logic [2:0] BRANCH_NEQ = 3'b010;
  localparam logic [2:0] BRANCH_GEZ = 3'b011;
  localparam logic [2:0] BRANCH_GTZ = 3'b100;
  localparam logic [2:0] BRANCH_LEZ = 3'b101;
  localparam logic [2:0] BRANCH_LTZ = 3'b110;

  logic [1:0]       bht_q [BHT_DEPTH];
  logic             pred_q;
  logic [IDX_W-1:0] idx_q;
  logic             live_q;
  logic [IDX_W-1:0] idx_f_s;
  logic             cond_s;
  logic             train_s;
  logic [1:0]       cnt_next_s;
  logic             unused_pc_s;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) begin
      return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    end else begin
      return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    end
  endfunction

  assign idx_f_s     = pcF[IDX_W+1:2];
  assign unused_pc_s = ^{pcF[31:IDX_W+2], pcF[1:0]};
  assign pred_takenF = bht_q[idx_f_s][1];
  assign pred_takenD = pred_q;

  // Branch condition evaluation on the forwarded operands.
  always_comb begin
    cond_s = 1'b0;
    case (branchcontrolD)
      BRANCH_EQ:  cond_s = (srca2D == srcb2D);
      BRANCH_NEQ: cond_s = (srca2D != srcb2D);
      BRANCH_GEZ: cond_s = ~srca2D[DATA_W-1];
      BRANCH_GTZ: cond_s = ~srca2D[DATA_W-1] & (srca2D != '0);
      BRANCH_LEZ: cond_s = srca2D[DATA_W-1] | (srca2D == '0);
      BRANCH_LTZ: cond_s = srca2D[DATA_W-1];
      default:    cond_s = 1'b0;
    endcase
  end

  assign pcsrcD      = branchD & cond_s;
  assign mispredictD = branchD & ~stallD & (pcsrcD != pred_q);
  // live_q blocks training on the first edge after reset release
  assign train_s     = branchD & ~stallD & ~flushD & live_q;
  assign cnt_next_s  = sat_step(bht_q[idx_q], pcsrcD);

  // BHT storage: one counter trained per cycle at most, no read bypass.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht_q[i] <= CNT_INIT;
      end
    end else if (train_s) begin
      bht_q[idx_q] <= cnt_next_s;
    end
  end

  // F->D prediction pipe; flush wins over stall.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_q <= 1'b0;
      idx_q  <= '0;
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
      if (flushD) begin
        pred_q <= 1'b0;
        idx_q  <= '0;
      end else if (!stallD) begin
        pred_q <= pred_takenF;
        idx_q  <= idx_f_s;
      end
    end
  end

`ifdef PERF_CNT_EN
  // Resolved-branch and mispredict counters, wrapping at 32 bits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_branches <= 32'd0;
      perf_mispred  <= 32'd0;
    end else if (train_s) begin
      perf_branches <= perf_branches + 32'd1;
      if (mispredictD) begin
        perf_mispred <= perf_mispred + 32'd1;
      end
    end
  end
`endif

endmodule
